// File: rtl/edge_arb_pkg.sv
// Shared constants for the edge event arbiter: default channel count and id width.
package edge_arb_pkg;
   localparam int N_DEF = 4;

   function automatic int id_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction
endpackage

// File: rtl/edge_event_arbiter_rr_pick.sv
// Combinational round-robin picker: lowest request at or after ptr, wrapping at N.
module rr_pick
   import edge_arb_pkg::*;
#(
   parameter int N = N_DEF,
   parameter int W = id_w(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic [W-1:0] gnt_id,
   output logic         any
);
   int idx;

   // Walk offsets from the far end so the closest request to ptr is written last.
   always_comb begin
      gnt_id = '0;
      any    = 1'b0;
      idx    = 0;
      for (int k = N - 1; k >= 0; k--) begin
         idx = (int'(ptr) + k) % N;
         if (req[idx]) begin
            gnt_id = W'(idx);
            any    = 1'b1;
         end
      end
   end
endmodule

// File: rtl/edge_event_arbiter.sv
// Rising-edge detector per channel with pending/overflow tracking and a
// round-robin arbitrated single-entry event output with valid/ready handshake.
module edge_event_arbiter
   import edge_arb_pkg::*;
#(
   parameter int N = N_DEF,
   localparam int W = id_w(N)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] data,
   input  logic [N-1:0] en,
   output logic         evt_valid,
   output logic [W-1:0] evt_id,
   input  logic         evt_ready,
   output logic [N-1:0] ovf,
   input  logic [N-1:0] ovf_clr
);
   logic [N-1:0] data_q;
   logic [N-1:0] pend;
   logic [W-1:0] ptr;
   logic [N-1:0] rise;
   logic [N-1:0] clr;
   logic [W-1:0] gnt_id;
   logic         any;
   logic         load;

   rr_pick #(.N(N), .W(W)) u_pick (
      .req    (pend),
      .ptr    (ptr),
      .gnt_id (gnt_id),
      .any    (any)
   );

   assign rise = data & ~data_q & en;
   assign load = ~evt_valid | evt_ready;

   always_comb begin
      clr = '0;
      if (load && any) clr[gnt_id] = 1'b1;
   end

   // data_q resets high so a level already high at release is not an edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q    <= '1;
         pend      <= '0;
         ovf       <= '0;
         ptr       <= '0;
         evt_valid <= 1'b0;
         evt_id    <= '0;
      end else begin
         data_q <= data;
         pend   <= ((pend & ~clr) | rise) & en;
         // A rise on a channel being granted this cycle re-arms it instead of overflowing.
         ovf    <= (ovf & ~ovf_clr) | (rise & pend & ~clr);
         if (load) begin
            evt_valid <= any;
            if (any) begin
               evt_id <= gnt_id;
               ptr    <= (gnt_id == W'(N - 1)) ? '0 : gnt_id + W'(1);
            end
         end
      end
   end
endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed self-checking bench for edge_event_arbiter with N=4.
module tb_edge_event_arbiter;
   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] data;
   logic [3:0] en;
   logic       evt_valid;
   logic [1:0] evt_id;
   logic       evt_ready;
   logic [3:0] ovf;
   logic [3:0] ovf_clr;

   int checks = 0;
   int errors = 0;

   edge_event_arbiter #(.N(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .data      (data),
      .en        (en),
      .evt_valid (evt_valid),
      .evt_id    (evt_id),
      .evt_ready (evt_ready),
      .ovf       (ovf),
      .ovf_clr   (ovf_clr)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; data = '0; en = 4'hF; evt_ready = 1'b0; ovf_clr = '0;
      step();
      rst_n = 1'b1;
      step();
      step();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; data = '0; en = 4'hF; evt_ready = 1'b0; ovf_clr = '0;
      step();
      checks++;
      if (evt_valid !== 1'b0 || evt_id !== 2'd0 || ovf !== 4'h0) begin
         errors++;
         $display("FAIL reset: valid=%b id=%0d ovf=%h required 0 0 0", evt_valid, evt_id, ovf);
      end
      rst_n = 1'b1;
      step();
      step();
   endtask

   task automatic test_single();
      do_reset();
      evt_ready = 1'b1;
      data = 4'b0100;
      step();
      checks++;
      if (evt_valid !== 1'b0) begin
         errors++; $display("FAIL single_latency: valid=%b required 0", evt_valid);
      end
      step();
      checks++;
      if (evt_valid !== 1'b1 || evt_id !== 2'd2) begin
         errors++; $display("FAIL single_event: valid=%b id=%0d required 1 2", evt_valid, evt_id);
      end
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (evt_valid !== 1'b0) begin
            errors++; $display("FAIL single_once: cycle %0d valid=%b required 0", i, evt_valid);
         end
      end
   endtask

   task automatic test_simultaneous();
      do_reset();
      evt_ready = 1'b1;
      data = 4'hF;
      step();
      for (int i = 0; i < 4; i++) begin
         step();
         checks++;
         if (evt_valid !== 1'b1 || evt_id !== 2'(i)) begin
            errors++;
            $display("FAIL simultaneous: slot %0d valid=%b id=%0d required 1 %0d", i, evt_valid, evt_id, i);
         end
      end
      step();
      checks++;
      if (evt_valid !== 1'b0) begin
         errors++; $display("FAIL simultaneous_drain: valid=%b required 0", evt_valid);
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      data = 4'b0010; step();
      data = 4'b0000; step();
      checks++;
      if (evt_valid !== 1'b1 || evt_id !== 2'd1) begin
         errors++; $display("FAIL bp_first: valid=%b id=%0d required 1 1", evt_valid, evt_id);
      end
      data = 4'b0010; step();
      data = 4'b0000; step();
      checks++;
      if (evt_valid !== 1'b1 || evt_id !== 2'd1 || ovf !== 4'h0) begin
         errors++; $display("FAIL bp_hold: valid=%b id=%0d ovf=%h required 1 1 0", evt_valid, evt_id, ovf);
      end
      // third pulse overflows while a clear is applied the same cycle: set wins
      data = 4'b0010; ovf_clr = 4'b0010; step();
      checks++;
      if (ovf !== 4'b0010 || evt_valid !== 1'b1 || evt_id !== 2'd1) begin
         errors++; $display("FAIL bp_ovf_set: ovf=%h valid=%b id=%0d required 2 1 1", ovf, evt_valid, evt_id);
      end
      data = 4'b0000; ovf_clr = 4'b0000; step();
      evt_ready = 1'b1;
      step();
      checks++;
      if (evt_valid !== 1'b1 || evt_id !== 2'd1) begin
         errors++; $display("FAIL bp_second: valid=%b id=%0d required 1 1", evt_valid, evt_id);
      end
      step();
      checks++;
      if (evt_valid !== 1'b0 || ovf !== 4'b0010) begin
         errors++; $display("FAIL bp_drain: valid=%b ovf=%h required 0 2", evt_valid, ovf);
      end
      ovf_clr = 4'b0010; step();
      ovf_clr = 4'b0000;
      checks++;
      if (ovf !== 4'h0) begin
         errors++; $display("FAIL bp_ovf_clr: ovf=%h required 0", ovf);
      end
   endtask

   task automatic test_fairness();
      do_reset();
      evt_ready = 1'b1;
      for (int r = 0; r < 4; r++) begin
         data = 4'b1001; step();
         step();
         checks++;
         if (evt_valid !== 1'b1 || evt_id !== 2'd0) begin
            errors++; $display("FAIL fair_ch0: round %0d valid=%b id=%0d required 1 0", r, evt_valid, evt_id);
         end
         data = 4'b0000; step();
         checks++;
         if (evt_valid !== 1'b1 || evt_id !== 2'd3) begin
            errors++; $display("FAIL fair_ch3: round %0d valid=%b id=%0d required 1 3", r, evt_valid, evt_id);
         end
         step();
      end
      checks++;
      if (ovf !== 4'h0) begin
         errors++; $display("FAIL fair_ovf: ovf=%h required 0", ovf);
      end
   endtask

   task automatic test_mask_reset();
      do_reset();
      evt_ready = 1'b1;
      en = 4'b1101; data = 4'b0010;
      step(); step(); step();
      checks++;
      if (evt_valid !== 1'b0) begin
         errors++; $display("FAIL mask_block: valid=%b required 0", evt_valid);
      end
      en = 4'hF; data = 4'b0000; evt_ready = 1'b0; step();
      data = 4'b0001; step();
      step();
      checks++;
      if (evt_valid !== 1'b1 || evt_id !== 2'd0) begin
         errors++; $display("FAIL mask_present: valid=%b id=%0d required 1 0", evt_valid, evt_id);
      end
      data = 4'b0101; step();
      en = 4'b1011; step();
      checks++;
      if (evt_valid !== 1'b1 || evt_id !== 2'd0) begin
         errors++; $display("FAIL mask_complete: valid=%b id=%0d required 1 0", evt_valid, evt_id);
      end
      en = 4'hF; evt_ready = 1'b1; step();
      checks++;
      if (evt_valid !== 1'b0) begin
         errors++; $display("FAIL mask_pend_cleared: valid=%b required 0", evt_valid);
      end
      evt_ready = 1'b0; data = 4'b0000; step();
      data = 4'b0001; step();
      step();
      checks++;
      if (evt_valid !== 1'b1) begin
         errors++; $display("FAIL reset_pre: valid=%b required 1", evt_valid);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (evt_valid !== 1'b0 || evt_id !== 2'd0) begin
         errors++; $display("FAIL reset_async: valid=%b id=%0d required 0 0", evt_valid, evt_id);
      end
      step();
      rst_n = 1'b1;
      evt_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (evt_valid !== 1'b0) begin
            errors++; $display("FAIL reset_level_high: cycle %0d valid=%b required 0", i, evt_valid);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_simultaneous();
      test_backpressure();
      test_fairness();
      test_mask_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
